// File: rtl/iob_pfsm_loader.sv
// iob_pfsm_loader
//   IOb-native bus initiator that programs an iob_pfsm LUT from an entry
//   stream. On start it writes SOFTRESET=1, then for every entry (in address
//   order) writes MEM_WORD_SELECT=k followed by the k-th DATA_W chunk of the
//   entry into the MEMORY window, then writes SOFTRESET=0 and pulses done_o.
//
// Ports
//   clk_i, arst_n_i, cke_i        : clock, async active-low reset, clock enable
//   start_i                       : begin a load (sampled in IDLE only)
//   lut_data_i/valid_i/ready_o    : LUT entry stream {next_state, outputs}
//   iob_valid_o/addr_o/wdata_o/
//   iob_wstrb_o/ready_i           : IOb-native write request
//   iob_rvalid_i/rdata_i          : read response, unused by a write-only master
//   busy_o, done_o                : load in progress / one-cycle completion pulse
module iob_pfsm_loader #(
    parameter int DATA_W               = 32,
    parameter int ADDR_W               = 16,
    parameter int STATE_W              = 2,
    parameter int INPUT_W              = 1,
    parameter int OUTPUT_W             = 1,
    parameter int SOFTRESET_ADDR       = 0,
    parameter int MEM_WORD_SELECT_ADDR = 4,
    parameter int MEMORY_ADDR          = 16
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    input  logic                        cke_i,
    input  logic                        start_i,
    input  logic [STATE_W+OUTPUT_W-1:0] lut_data_i,
    input  logic                        lut_valid_i,
    output logic                        lut_ready_o,
    output logic                        iob_valid_o,
    output logic [ADDR_W-1:0]           iob_addr_o,
    output logic [DATA_W-1:0]           iob_wdata_o,
    output logic [DATA_W/8-1:0]         iob_wstrb_o,
    input  logic                        iob_ready_i,
    input  logic                        iob_rvalid_i,
    input  logic [DATA_W-1:0]           iob_rdata_i,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int LUT_W     = STATE_W + OUTPUT_W;
    localparam int N_CHUNKS  = (LUT_W + DATA_W - 1) / DATA_W;
    localparam int N_ENTRIES = 1 << (STATE_W + INPUT_W);
    localparam int BSHIFT    = $clog2(DATA_W / 8);
    localparam int E_W       = STATE_W + INPUT_W;
    localparam int K_W       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int PAD_W     = N_CHUNKS * DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        RST_ASSERT,
        WAIT_ENTRY,
        SEL,
        MEM,
        RST_RELEASE,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [E_W-1:0]     e, e_n;
    logic [K_W-1:0]     k, k_n;
    logic [LUT_W-1:0]   ent, ent_n;

    logic               valid_d, lut_ready_d, busy_d, done_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic [PAD_W-1:0]   pad;

    // Read channel is not used by a write-only initiator.
    logic unused_rd;
    always_comb unused_rd = ^{iob_rvalid_i, iob_rdata_i};

    // Next-state logic. In bus states the registered iob_valid_o is already
    // high, so iob_ready_i alone marks acceptance.
    always_comb begin
        state_n = state;
        e_n     = e;
        k_n     = k;
        ent_n   = ent;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = RST_ASSERT;
                    e_n     = '0;
                    k_n     = '0;
                end
            end
            RST_ASSERT: begin
                if (iob_ready_i) state_n = WAIT_ENTRY;
            end
            WAIT_ENTRY: begin
                if (lut_valid_i) begin
                    ent_n   = lut_data_i;
                    k_n     = '0;
                    state_n = SEL;
                end
            end
            SEL: begin
                if (iob_ready_i) state_n = MEM;
            end
            MEM: begin
                if (iob_ready_i) begin
                    if (k != K_W'(N_CHUNKS - 1)) begin
                        k_n     = k + K_W'(1);
                        state_n = SEL;
                    end else if (e != E_W'(N_ENTRIES - 1)) begin
                        e_n     = e + E_W'(1);
                        state_n = WAIT_ENTRY;
                    end else begin
                        state_n = RST_RELEASE;
                    end
                end
            end
            RST_RELEASE: begin
                if (iob_ready_i) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values and then registered,
    // which gives the same cycle timing as a Moore decode of the current
    // state while keeping every output glitch-free.
    always_comb begin
        valid_d     = 1'b0;
        lut_ready_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        pad         = PAD_W'(ent_n);
        unique case (state_n)
            RST_ASSERT: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                addr_d  = ADDR_W'(SOFTRESET_ADDR);
                wdata_d = DATA_W'(1);
            end
            WAIT_ENTRY: begin
                lut_ready_d = 1'b1;
                busy_d      = 1'b1;
            end
            SEL: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                addr_d  = ADDR_W'(MEM_WORD_SELECT_ADDR);
                wdata_d = DATA_W'(k_n);
            end
            MEM: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                addr_d  = ADDR_W'(MEMORY_ADDR + (32'(e_n) << BSHIFT));
                wdata_d = pad[k_n*DATA_W +: DATA_W];
            end
            RST_RELEASE: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                addr_d  = ADDR_W'(SOFTRESET_ADDR);
                wdata_d = '0;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= IDLE;
            e           <= '0;
            k           <= '0;
            ent         <= '0;
            lut_ready_o <= 1'b0;
            iob_valid_o <= 1'b0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (cke_i) begin
            state       <= state_n;
            e           <= e_n;
            k           <= k_n;
            ent         <= ent_n;
            lut_ready_o <= lut_ready_d;
            iob_valid_o <= valid_d;
            iob_addr_o  <= addr_d;
            iob_wdata_o <= wdata_d;
            iob_wstrb_o <= valid_d ? '1 : '0;
            busy_o      <= busy_d;
            done_o      <= done_d;
        end
    end

endmodule
